pwm_duty_sequencer: RTL

//   Turns debounced up/down switch levels into a brightness level (0..MAX_LEVEL)
//   for the seven-segment display and an 8-bit duty cycle for the PWM divider.

---
 rtl/pwm_duty_sequencer_pkg.sv | 9 +
 rtl/pwm_duty_sequencer_btn_press_gen.sv | 39 +++
 rtl/pwm_duty_sequencer.sv | 77 +++++++
 3 files changed

// File: rtl/pwm_duty_sequencer_pkg.sv
// pwm_duty_sequencer_pkg: shared widths, slew FSM states and duty step helper.
package pwm_duty_sequencer_pkg;
    localparam int DUTY_W  = 8;
    localparam int LEVEL_W = 4;
    typedef enum logic {IDLE, RAMP} state_t;
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur, input logic [DUTY_W-1:0] tgt);
        return (cur < tgt) ? cur + 1'b1 : cur - 1'b1;
    endfunction
endpackage

// File: rtl/pwm_duty_sequencer_btn_press_gen.sv
// btn_press_gen: one-clk press pulse from a debounced button level.
// Auto-repeat while held alone is built only when AUTO_REPEAT_EN is defined.
module btn_press_gen #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    input  logic i_other,
    output logic o_press
);
    logic r_prev;
    logic w_edge;
    assign w_edge = i_btn & ~r_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b0;
        else        r_prev <= i_btn;
    end
`ifdef AUTO_REPEAT_EN
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    logic [CNT_W-1:0] r_cnt;
    logic w_rep;
    assign w_rep   = i_btn & ~i_other & (r_cnt == CNT_W'(REPEAT_DELAY));
    assign o_press = w_edge | w_rep;
    // r_cnt holds clocks since press; after each repeat it is rewound so the next fires REPEAT_RATE later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_cnt <= '0;
        else if (!i_btn || i_other) r_cnt <= '0;
        else if (w_edge)            r_cnt <= CNT_W'(1);
        else if (w_rep)             r_cnt <= CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
        else if (r_cnt != '0)       r_cnt <= r_cnt + 1'b1;
    end
`else
    logic w_unused;
    assign w_unused = i_other | (REPEAT_DELAY == 0) | (REPEAT_RATE == 0);
    assign o_press  = w_edge;
`endif
endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: up/down presses -> level 0..MAX_LEVEL and a soft-slewed PWM duty.
// Optional auto-repeat of held buttons is enabled by defining AUTO_REPEAT_EN.
module pwm_duty_sequencer
    import pwm_duty_sequencer_pkg::*;
#(
    parameter int MAX_LEVEL    = 10,
    parameter int STEP         = 25,
    parameter int RAMP_DIV     = 5000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_btn_up,
    input  logic               i_btn_dn,
    output logic [LEVEL_W-1:0] o_level,
    output logic [DUTY_W-1:0]  o_duty,
    output logic               o_busy,
    output logic               o_update
);
    localparam int TICK_W = $clog2(RAMP_DIV + 1);
    logic               w_up_press, w_dn_press, w_inc, w_dec, w_chg;
    logic [LEVEL_W-1:0] r_level, w_level_nxt;
    logic [DUTY_W-1:0]  r_duty, w_target, w_target_nxt, w_duty_step;
    logic [TICK_W-1:0]  r_tick;
    state_t             r_state;
    logic               r_busy, r_update;

    btn_press_gen #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
        .clk(clk), .rst_n(rst_n), .i_btn(i_btn_up), .i_other(i_btn_dn), .o_press(w_up_press));
    btn_press_gen #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
        .clk(clk), .rst_n(rst_n), .i_btn(i_btn_dn), .i_other(i_btn_up), .o_press(w_dn_press));

    assign w_inc        = w_up_press & ~w_dn_press & (r_level != LEVEL_W'(MAX_LEVEL));
    assign w_dec        = w_dn_press & ~w_up_press & (r_level != '0);
    assign w_chg        = w_inc | w_dec;
    assign w_level_nxt  = w_inc ? r_level + 1'b1 : w_dec ? r_level - 1'b1 : r_level;
    assign w_target     = DUTY_W'(r_level * STEP);
    assign w_target_nxt = DUTY_W'(w_level_nxt * STEP);
    assign w_duty_step  = step_toward(r_duty, w_target);

    // A level change wins over a pending slew step: the tick restarts and duty holds this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level  <= '0;
            r_duty   <= '0;
            r_tick   <= '0;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_update <= 1'b0;
        end else begin
            r_level  <= w_level_nxt;
            r_update <= w_chg;
            if (w_chg) begin
                r_tick  <= '0;
                r_state <= (w_target_nxt == r_duty) ? IDLE : RAMP;
                r_busy  <= w_target_nxt != r_duty;
            end else if (r_state == RAMP) begin
                if (r_tick == TICK_W'(RAMP_DIV - 1)) begin
                    r_tick <= '0;
                    r_duty <= w_duty_step;
                    if (w_duty_step == w_target) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end
        end
    end

    assign o_level  = r_level;
    assign o_duty   = r_duty;
    assign o_busy   = r_busy;
    assign o_update = r_update;
endmodule
